imem_prog: RTL
==============

IMEM_PROG -- requirements
Module: imem_prog

Interface
REQ-001 Parameter N, default 32: instruction word width in bits.
REQ-002 Parameter DEPTH, default 64: number of words stored.
REQ-003 Parameter AW, default 8: address port width; AW SHALL be at least clog2(DEPTH).
REQ-004 Parameter FILL, default 0 (N bits): power-up content of every word.
REQ-005 Ports SHALL be, clock and reset first, as listed below.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request.
- f_addr  in  AW  fetch word address.
- f_valid  out  1  fetch response valid.
- f_q  out  N  fetched instruction word.
- f_fault  out  1  fetch address was out of range.
- f_stall  out  1  fetch port unavailable because a load is active.
- ld_start  in  1  begin a program load.
- ld_base  in  AW  first word address of the load.
- ld_valid  in  1  load data beat offered.
- ld_data  in  N  load data word.
- ld_last  in  1  marks the final beat.
- ld_ready  out  1  load beat accepted when high together with ld_valid.
- ld_done  out  1  one-cycle pulse at end of load.
- ld_err  out  1  sticky overflow flag.
- ld_count  out  AW+1  number of beats accepted in the current or last load.

Function
REQ-006 Storage SHALL be DEPTH words of N bits, each FILL at time zero; reset SHALL NOT alter storage.
REQ-007 FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-008 IDLE -> LOAD on ld_start; LOAD -> DONE on an accepted beat with ld_last=1; DONE -> IDLE unconditionally after one cycle.
REQ-009 ld_start in LOAD or DONE SHALL be ignored.
REQ-010 On entry to LOAD: write pointer <= ld_base, ld_count <= 0, ld_err <= 0.
REQ-011 ld_ready SHALL be 1 exactly while in LOAD; ld_ready is combinational from state only.
REQ-012 Accepted beat (ld_valid & ld_ready): if pointer < DEPTH, write mem[pointer] <= ld_data; in all cases pointer++ and ld_count++.
REQ-013 If pointer >= DEPTH on an accepted beat, the word SHALL be dropped, ld_err set, and ld_err held until the next ld_start.
REQ-014 ld_count SHALL saturate at 2^(AW+1)-1 and hold its final value after DONE until the next ld_start.
REQ-015 ld_done SHALL be 1 only in DONE, i.e. the cycle after the ld_last beat.
REQ-016 f_stall SHALL be 1 in LOAD and DONE, and in IDLE while ld_start=1.
REQ-017 Fetch latency SHALL be 1: when f_req=1 and f_stall=0 in cycle t, then in cycle t+1 f_valid=1 and f_q=mem[f_addr], with f_fault=0.
REQ-018 If that f_addr >= DEPTH: f_valid=1, f_fault=1, f_q=0 in cycle t+1.
REQ-019 When f_req=0 or f_stall=1 in cycle t, f_valid=0 and f_fault=0 in t+1.
REQ-020 f_q SHALL hold its last value when f_valid=0.
REQ-021 Back-to-back fetches SHALL be sustained at one per cycle.
REQ-022 Read and write never coincide, because fetch is blocked during LOAD.
REQ-023 A fetch issued in the cycle after DONE SHALL return the newly loaded data.

Reset
REQ-024 On reset=1 at a clock edge the block SHALL enter IDLE and clear f_valid, f_fault, f_q, ld_done, ld_err, ld_count and the write pointer.
REQ-025 Reset SHALL override every other input in the same cycle.
REQ-026 Reset mid-load SHALL abort the load: words already written remain; no ld_done pulse is produced.

Verification
REQ-027 Power-up, no load; fetch addr 5 -> f_valid=1, f_q=FILL next cycle; back-to-back fetches of addrs 0..63 each return FILL.
REQ-028 ld_base=0; 16 beats 0x8b000002, 0x8b000003, 0xb40000de, ... with ld_last on beat 16 -> ld_done pulse one cycle after beat 16, ld_count=16; fetches 0..15 return the words in order.
REQ-029 ld_valid toggling 1/0 during LOAD -> only beats with ld_valid=1 written; f_req during LOAD -> f_stall=1 and f_valid=0 next cycle.
REQ-030 DEPTH=64, ld_base=62, 4 beats -> addrs 62 and 63 written, 2 words dropped, ld_err=1, ld_count=4; fetch addr 64 -> f_fault=1, f_q=0.
REQ-031 Reset asserted after 3 of 8 beats -> IDLE, no ld_done; addrs base..base+2 hold new data, base+3 onward unchanged.
REQ-032 ld_start and f_req in the same IDLE cycle -> load entered, f_valid=0 next cycle; ld_start during LOAD -> pointer and ld_count unaffected.

Source files
------------

// File: rtl/imem_prog.sv
// Instruction memory with a single-cycle fetch port and a streaming program-load port.
// Loading blocks fetch, so the storage array never sees a read and a write in the same cycle.
module imem_prog #(
    parameter int             N     = 32,
    parameter int             DEPTH = 64,
    parameter int             AW    = 8,
    parameter logic [N-1:0]   FILL  = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_valid,
    output logic [N-1:0]  f_q,
    output logic          f_fault,
    output logic          f_stall,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic          ld_valid,
    input  logic [N-1:0]  ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          ld_err,
    output logic [AW:0]   ld_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] SAT_W   = '1;

    state_t state;
    state_t state_nxt;

    // NOTE: the array has no reset; its power-up value comes from the declaration
    // initialiser, so a reset never disturbs a program that is already loaded.
    logic [N-1:0] mem [DEPTH] = '{default: FILL};

    // One bit wider than an address so an overflowing load can never wrap back in range.
    logic [AW:0] wptr;
    logic        beat;
    logic        wr_in_range;
    logic        fetch;
    logic        rd_in_range;

    assign ld_ready    = (state == LOAD);
    assign ld_done     = (state == DONE);
    assign f_stall     = (state != IDLE) || ld_start;
    assign beat        = ld_ready && ld_valid;
    assign wr_in_range = (wptr < DEPTH_W);
    assign fetch       = f_req && !f_stall;
    assign rd_in_range = ({1'b0, f_addr} < DEPTH_W);

    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld_start) state_nxt = LOAD;
            LOAD:    if (beat && ld_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else if (state == IDLE && ld_start) begin
            wptr     <= {1'b0, ld_base};
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else if (beat) begin
            if (wptr != SAT_W)     wptr     <= wptr + 1'b1;
            if (ld_count != SAT_W) ld_count <= ld_count + 1'b1;
            if (!wr_in_range)      ld_err   <= 1'b1;
        end
    end

    // Reset gates the write so an aborting cycle cannot commit its beat.
    always_ff @(posedge clk) begin
        if (!reset && beat && wr_in_range) mem[wptr[IW-1:0]] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_valid <= 1'b0;
            f_fault <= 1'b0;
            f_q     <= '0;
        end else if (fetch) begin
            f_valid <= 1'b1;
            if (rd_in_range) begin
                f_q     <= mem[f_addr[IW-1:0]];
                f_fault <= 1'b0;
            end else begin
                f_q     <= '0;
                f_fault <= 1'b1;
            end
        end else begin
            f_valid <= 1'b0;
            f_fault <= 1'b0;
        end
    end

endmodule
